// File: rtl/acia_rx_fifo_if.sv
// Bus between the serial receiver / ACIA register logic (master) and the
// receive FIFO (slave). No backpressure exists: rx_stb and rd are one-cycle
// requests with no ready; the FIFO reports acceptance only through its flags.
interface acia_rx_fifo_if #(
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  rx_dat;
   logic        rx_stb;
   logic        rx_err;
   logic        rd;
   logic        flush;
   logic        clr_ovr;
   logic [7:0]  dout;
   logic        dout_err;
   logic        empty;
   logic        full;
   logic        half;
   logic [AW:0] count;
   logic        ovr;

   modport master (
      output rx_dat, rx_stb, rx_err, rd, flush, clr_ovr,
      input  dout, dout_err, empty, full, half, count, ovr
   );

   modport slave (
      input  rx_dat, rx_stb, rx_err, rd, flush, clr_ovr,
      output dout, dout_err, empty, full, half, count, ovr
   );
endinterface

// File: rtl/acia_rx_fifo.sv
// First-word-fall-through receive buffer for the ACIA: stores {err, byte}
// per received character and exposes the oldest one combinationally.
module acia_rx_fifo #(
   parameter int DEPTH = 16
) (
   input logic          clk,
   input logic          rst,
   acia_rx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);

   logic [8:0]    mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [AW:0]   count_q, count_d;
   logic          ovr_q, ovr_d;
   logic          empty, full;
   logic          push, pop, drop;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);

   // A full buffer still accepts a byte when a read frees a slot in the
   // same cycle; an empty buffer ignores rd because nothing was visible.
   assign push = bus.rx_stb & (~full | bus.rd);
   assign pop  = bus.rd & ~empty;
   assign drop = bus.rx_stb & full & ~bus.rd;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      count_d = count_q;
      ovr_d   = ovr_q;
      if (bus.flush) begin
         wp_d    = '0;
         rp_d    = '0;
         count_d = '0;
         ovr_d   = 1'b0;
      end else begin
         if (push) wp_d = wp_q + AW'(1);
         if (pop)  rp_d = rp_q + AW'(1);
         if (push && !pop)      count_d = count_q + (AW+1)'(1);
         else if (pop && !push) count_d = count_q - (AW+1)'(1);
         if (drop)             ovr_d = 1'b1;
         else if (bus.clr_ovr) ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
      end
   end

   // Storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (push && !bus.flush) mem_q[wp_q] <= {bus.rx_err, bus.rx_dat};
   end

   assign bus.dout     = empty ? 8'h00 : mem_q[rp_q][7:0];
   assign bus.dout_err = empty ? 1'b0  : mem_q[rp_q][8];
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.half     = (count_q >= HALF_CNT);
   assign bus.count    = count_q;
   assign bus.ovr      = ovr_q;
endmodule

// File: tb/tb_acia_rx_fifo.sv
// Directed bench for acia_rx_fifo with DEPTH = 4: a vector table of
// per-cycle stimulus and hand-computed results, plus async-reset sequences.
module tb_acia_rx_fifo;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   acia_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

   acia_rx_fifo #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       stb;
      logic [7:0] dat;
      logic       err;
      logic       rd;
      logic       fl;
      logic       clr;
      logic [7:0] e_dout;
      logic       e_err;
      logic [2:0] e_cnt;
      logic       e_ovr;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic stb, input logic [7:0] dat, input logic err,
                      input logic rd, input logic fl, input logic clr,
                      input logic [7:0] e_dout, input logic e_err,
                      input logic [2:0] e_cnt, input logic e_ovr);
      vec_t v;
      v.stb = stb; v.dat = dat; v.err = err; v.rd = rd; v.fl = fl; v.clr = clr;
      v.e_dout = e_dout; v.e_err = e_err; v.e_cnt = e_cnt; v.e_ovr = e_ovr;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      bus.rx_stb = 1'b0; bus.rx_dat = 8'h00; bus.rx_err = 1'b0;
      bus.rd = 1'b0; bus.flush = 1'b0; bus.clr_ovr = 1'b0;
   endtask

   // Flags are derived here from the expected count, independently of the DUT.
   task automatic check(input string name, input logic [7:0] e_dout, input logic e_err,
                        input logic [2:0] e_cnt, input logic e_ovr);
      logic e_empty, e_full, e_half;
      e_empty = (e_cnt == 3'd0);
      e_full  = (e_cnt == 3'd4);
      e_half  = (e_cnt >= 3'd2);
      checks++;
      if (bus.dout !== e_dout || bus.dout_err !== e_err || bus.count !== e_cnt ||
          bus.ovr !== e_ovr || bus.empty !== e_empty || bus.full !== e_full ||
          bus.half !== e_half) begin
         errors++;
         $display("FAIL %s: got dout=%h err=%b cnt=%0d ovr=%b empty=%b full=%b half=%b, want dout=%h err=%b cnt=%0d ovr=%b empty=%b full=%b half=%b",
                  name, bus.dout, bus.dout_err, bus.count, bus.ovr, bus.empty, bus.full,
                  bus.half, e_dout, e_err, e_cnt, e_ovr, e_empty, e_full, e_half);
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      bus.rx_stb = v.stb; bus.rx_dat = v.dat; bus.rx_err = v.err;
      bus.rd = v.rd; bus.flush = v.fl; bus.clr_ovr = v.clr;
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      // Ordering and pointer wrap: bytes 01..0A with interleaved pops
      add(1,8'h01,0,0,0,0, 8'h01,0,1,0);
      add(1,8'h02,0,0,0,0, 8'h01,0,2,0);
      add(1,8'h03,0,0,0,0, 8'h01,0,3,0);
      add(0,8'h00,0,1,0,0, 8'h02,0,2,0);
      add(1,8'h04,0,0,0,0, 8'h02,0,3,0);
      add(1,8'h05,0,1,0,0, 8'h03,0,3,0);
      add(1,8'h06,0,0,0,0, 8'h03,0,4,0);
      add(0,8'h00,0,1,0,0, 8'h04,0,3,0);
      add(0,8'h00,0,1,0,0, 8'h05,0,2,0);
      add(1,8'h07,0,1,0,0, 8'h06,0,2,0);
      add(1,8'h08,0,0,0,0, 8'h06,0,3,0);
      add(0,8'h00,0,1,0,0, 8'h07,0,2,0);
      add(1,8'h09,0,1,0,0, 8'h08,0,2,0);
      add(1,8'h0A,0,0,0,0, 8'h08,0,3,0);
      add(0,8'h00,0,1,0,0, 8'h09,0,2,0);
      add(0,8'h00,0,1,0,0, 8'h0A,0,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      // Full and overrun
      add(1,8'h10,0,0,0,0, 8'h10,0,1,0);
      add(1,8'h11,0,0,0,0, 8'h10,0,2,0);
      add(1,8'h12,0,0,0,0, 8'h10,0,3,0);
      add(1,8'h13,0,0,0,0, 8'h10,0,4,0);
      add(1,8'h14,0,0,0,0, 8'h10,0,4,1);
      add(0,8'h00,0,0,0,0, 8'h10,0,4,1);
      add(0,8'h00,0,1,0,0, 8'h11,0,3,1);
      add(0,8'h00,0,1,0,0, 8'h12,0,2,1);
      add(0,8'h00,0,1,0,0, 8'h13,0,1,1);
      add(0,8'h00,0,0,0,1, 8'h13,0,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      // Full + push + pop, then empty + push + pop
      add(1,8'h20,0,0,0,0, 8'h20,0,1,0);
      add(1,8'h21,0,0,0,0, 8'h20,0,2,0);
      add(1,8'h22,0,0,0,0, 8'h20,0,3,0);
      add(1,8'h23,0,0,0,0, 8'h20,0,4,0);
      add(1,8'h55,0,1,0,0, 8'h21,0,4,0);
      add(0,8'h00,0,1,0,0, 8'h22,0,3,0);
      add(0,8'h00,0,1,0,0, 8'h23,0,2,0);
      add(0,8'h00,0,1,0,0, 8'h55,0,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      add(1,8'h66,0,1,0,0, 8'h66,0,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      // Overrun and clr_ovr in the same cycle
      add(1,8'h70,0,0,0,0, 8'h70,0,1,0);
      add(1,8'h71,0,0,0,0, 8'h70,0,2,0);
      add(1,8'h72,0,0,0,0, 8'h70,0,3,0);
      add(1,8'h73,0,0,0,0, 8'h70,0,4,0);
      add(1,8'h74,0,0,0,1, 8'h70,0,4,1);
      add(0,8'h00,0,0,0,1, 8'h70,0,4,0);
      // Flush priority with 3 entries and ovr set
      add(0,8'h00,0,1,0,0, 8'h71,0,3,0);
      add(1,8'h75,0,0,0,0, 8'h71,0,4,0);
      add(1,8'h76,0,0,0,0, 8'h71,0,4,1);
      add(0,8'h00,0,1,0,0, 8'h72,0,3,1);
      add(1,8'h77,0,1,1,1, 8'h00,0,0,0);
      add(0,8'h00,0,0,0,0, 8'h00,0,0,0);
      // Error tagging, and error flag gated when empty
      add(1,8'h41,1,0,0,0, 8'h41,1,1,0);
      add(1,8'h42,0,0,0,0, 8'h41,1,2,0);
      add(0,8'h00,0,1,0,0, 8'h42,0,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);
      add(1,8'h43,1,0,0,0, 8'h43,1,1,0);
      add(0,8'h00,0,1,0,0, 8'h00,0,0,0);

      // Reset state
      #12;
      check("reset_state", 8'h00, 1'b0, 3'd0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
         check($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_ovr);
      end

      // Reset mid-burst, asserted between clock edges
      begin
         vec_t v;
         v.stb = 1; v.dat = 8'hA5; v.err = 1; v.rd = 0; v.fl = 0; v.clr = 0;
         apply(v);
         check("pre_reset_push", 8'hA5, 1'b1, 3'd1, 1'b0);
         #2 rst = 1'b1;
         #1;
         check("async_reset_now", 8'h00, 1'b0, 3'd0, 1'b0);
         rst = 1'b0;
         v.dat = 8'h3C; v.err = 0;
         apply(v);
         check("post_reset_push", 8'h3C, 1'b0, 3'd1, 1'b0);
      end

      // Overrun set, then async reset clears ovr as well
      begin
         vec_t v;
         v.stb = 1; v.err = 0; v.rd = 0; v.fl = 0; v.clr = 0;
         for (int k = 0; k < 4; k++) begin
            v.dat = 8'(8'h80 + k);
            apply(v);
         end
         check("refill_ovr", 8'h3C, 1'b0, 3'd4, 1'b1);
         #2 rst = 1'b1;
         #1;
         check("reset_clears_ovr", 8'h00, 1'b0, 3'd0, 1'b0);
         rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
